// File: rtl/seg_scan_driver_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
package seg_scan_driver_pkg;

  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_OFF = '0;

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg_scan_driver_blink_gen.sv
// Blink phase generator: counts frame ticks and toggles blink_phase every BLINK_FRAMES frames.
module seg_blink_gen #(
  parameter int BLINK_FRAMES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  output logic blink_phase,
  output logic phase_next
);

  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frame_cnt;
  logic          last;

  // phase_next is the phase that will hold once the pending frame tick lands.
  assign last       = (frame_cnt == FRAME_LAST);
  assign phase_next = blink_phase ^ last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (last) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with per-frame input capture and digit blinking.
// Define SEG_SCAN_DEGHOST_EN to insert BLANK_CYCLES of dark time between digits.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SEG_W*NUM_DIGITS-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]       dig_en,
  input  logic [NUM_DIGITS-1:0]       blink_mask,
  output logic [SEG_W-1:0]            seg_out,
  output logic [NUM_DIGITS-1:0]       an_out,
  output logic                        frame_tick
);

  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int CMAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] SHOW_LAST = CW'(SCAN_DIV - 1);
`ifdef SEG_SCAN_DEGHOST_EN
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
`endif

  scan_state_t                 state, state_n;
  logic [IW-1:0]               idx, idx_n, idx_inc;
  logic [CW-1:0]               cnt, cnt_n;
  logic                        running, wrap, frame_start;
  logic [SEG_W*NUM_DIGITS-1:0] seg_sh, seg_nx;
  logic [NUM_DIGITS-1:0]       en_sh, en_nx, mask_sh, mask_nx, an_d;
  logic                        phase_sh, phase_nx, blink_phase, phase_next, lit;
  logic [SEG_W-1:0]            seg_d;

  seg_blink_gen #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .blink_phase(blink_phase),
    .phase_next (phase_next)
  );

  assign idx_inc = (idx == IDX_LAST) ? '0 : idx + 1'b1;

  // The first edge after reset behaves like a frame-start entry into SHOW for digit 0.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt + 1'b1;
    wrap    = 1'b0;
    if (!running) begin
      state_n = SHOW;
      idx_n   = '0;
      cnt_n   = '0;
    end else if (state == SHOW) begin
      if (cnt == SHOW_LAST) begin
        cnt_n = '0;
`ifdef SEG_SCAN_DEGHOST_EN
        state_n = BLANK;
`else
        idx_n = idx_inc;
        wrap  = (idx == IDX_LAST);
`endif
      end
    end
`ifdef SEG_SCAN_DEGHOST_EN
    else if (cnt == BLANK_LAST) begin
      cnt_n   = '0;
      state_n = SHOW;
      idx_n   = idx_inc;
      wrap    = (idx == IDX_LAST);
    end
`endif
  end

  assign frame_start = !running || wrap;
  assign seg_nx      = frame_start ? seg_in     : seg_sh;
  assign en_nx       = frame_start ? dig_en     : en_sh;
  assign mask_nx     = frame_start ? blink_mask : mask_sh;
  // The blink gen only sees the tick a cycle into the frame, so use its look-ahead phase here.
  assign phase_nx    = wrap ? phase_next : (running ? phase_sh : blink_phase);

  always_comb begin
    an_d  = '0;
    seg_d = SEG_OFF;
    lit   = (state_n == SHOW) && en_nx[idx_n] && !(mask_nx[idx_n] && phase_nx);
    if (lit) begin
      an_d[idx_n] = 1'b1;
      seg_d       = seg_nx[int'(idx_n)*SEG_W +: SEG_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SHOW;
      idx        <= '0;
      cnt        <= '0;
      running    <= 1'b0;
      seg_sh     <= '0;
      en_sh      <= '0;
      mask_sh    <= '0;
      phase_sh   <= 1'b0;
      an_out     <= '0;
      seg_out    <= SEG_OFF;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      running    <= 1'b1;
      seg_sh     <= seg_nx;
      en_sh      <= en_nx;
      mask_sh    <= mask_nx;
      phase_sh   <= phase_nx;
      an_out     <= an_d;
      seg_out    <= seg_d;
      frame_tick <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed, table-driven bench for seg_scan_driver (4 digits, short scan/blank/blink periods).
`timescale 1ns/1ps
module tb_seg_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BC = 2;
  localparam int BF = 2;
`ifdef SEG_SCAN_DEGHOST_EN
  localparam int GAP = BC;
`else
  localparam int GAP = 0;
`endif
  localparam int SLOT   = SD + GAP;
  localparam int PERIOD = ND * SLOT;
  localparam int NF     = 6;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_8 = 7'h7F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [27:0] seg_in;
  logic [3:0]  dig_en;
  logic [3:0]  blink_mask;
  logic [6:0]  seg_out;
  logic [3:0]  an_out;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail   = 0;

  seg_scan_driver #(
    .NUM_DIGITS  (ND),
    .SCAN_DIV    (SD),
    .BLANK_CYCLES(BC),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .dig_en    (dig_en),
    .blink_mask(blink_mask),
    .seg_out   (seg_out),
    .an_out    (an_out),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // lit[f] = digits expected to light in frame f (hand-derived from dig_en, blink_mask, BF=2).
  typedef struct {
    logic [27:0]      seg;
    logic [3:0]       en;
    logic [3:0]       mask;
    logic [5:0][3:0]  lit;
  } vec_t;

  vec_t vecs [5];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_cycle(input int s, input logic [27:0] seg_w, input logic [3:0] lit_now);
    int k, slot, pos;
    logic [3:0] an_e;
    logic [6:0] seg_e;
    logic       tick_e;
    k     = (s - 1) % PERIOD;
    slot  = k / SLOT;
    pos   = k % SLOT;
    an_e  = '0;
    seg_e = '0;
    if (pos < SD && lit_now[slot]) begin
      an_e[slot] = 1'b1;
      seg_e      = seg_w[slot*7 +: 7];
    end
    tick_e = (s > 1) && (k == 0);
    check_output($sformatf("an_out@%0d", s), 32'(an_out), 32'(an_e));
    check_output($sformatf("seg_out@%0d", s), 32'(seg_out), 32'(seg_e));
    check_output($sformatf("frame_tick@%0d", s), 32'(frame_tick), 32'(tick_e));
    check_output($sformatf("an_single@%0d", s), 32'($countones(an_out) <= 1), 32'd1);
  endtask

  // Hold reset a couple of cycles, check the cleared outputs, then release on a falling edge.
  task automatic apply_stimulus(input logic [27:0] seg, input logic [3:0] en, input logic [3:0] mask);
    seg_in     = seg;
    dig_en     = en;
    blink_mask = mask;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_an_out", 32'(an_out), 32'd0);
    check_output("rst_seg_out", 32'(seg_out), 32'd0);
    check_output("rst_frame_tick", 32'(frame_tick), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [27:0] all8, digits, alt, new_word;

    rst_n      = 1'b0;
    seg_in     = '0;
    dig_en     = '0;
    blink_mask = '0;

    all8   = {SEG_8, SEG_8, SEG_8, SEG_8};
    digits = {SEG_3, SEG_2, SEG_1, SEG_0};
    alt    = {SEG_5, SEG_4, SEG_3, SEG_2};

    vecs[0] = '{all8,   4'hF,    4'h0,    {4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF}};
    vecs[1] = '{digits, 4'b1010, 4'h0,    {4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA}};
    vecs[2] = '{all8,   4'hF,    4'b0001, {4'hF, 4'hF, 4'hE, 4'hE, 4'hF, 4'hF}};
    vecs[3] = '{digits, 4'b0111, 4'b0110, {4'h7, 4'h7, 4'h1, 4'h1, 4'h7, 4'h7}};
    vecs[4] = '{alt,    4'b1001, 4'hF,    {4'h9, 4'h9, 4'h0, 4'h0, 4'h9, 4'h9}};

    for (int r = 0; r < 5; r++) begin
      apply_stimulus(vecs[r].seg, vecs[r].en, vecs[r].mask);
      for (int s = 1; s <= NF * PERIOD; s++) begin
        @(negedge clk);
        expect_cycle(s, vecs[r].seg, vecs[r].lit[(s - 1) / PERIOD]);
      end
    end

    // Digit 2 code changes while digit 1 is lit: old code this frame, new code next frame.
    apply_stimulus(all8, 4'hF, 4'h0);
    new_word = {SEG_8, SEG_1, SEG_8, SEG_8};
    for (int s = 1; s <= 2 * PERIOD; s++) begin
      @(negedge clk);
      expect_cycle(s, (s <= PERIOD) ? all8 : new_word, 4'hF);
      if (s == SLOT + 2) seg_in[20:14] = SEG_1;
    end

    // Reset asserted while digit 3 is lit must darken outputs without waiting for a clock.
    apply_stimulus(digits, 4'hF, 4'h0);
    for (int s = 1; s <= 3 * SLOT + 2; s++) begin
      @(negedge clk);
      expect_cycle(s, digits, 4'hF);
    end
    rst_n = 1'b0;
    #1;
    check_output("async_rst_an_out", 32'(an_out), 32'd0);
    check_output("async_rst_seg_out", 32'(seg_out), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 1; s <= PERIOD + 1; s++) begin
      @(negedge clk);
      expect_cycle(s, digits, 4'hF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
